// File: rtl/act_pkg.sv
// Shared constants for the activation repacker: lane counts, lane width and derived bus widths.
// Pure declarations, no logic.
// Used by act_repacker_if, act_fifo and act_repacker.
package act_pkg;

  localparam int ACT_BITS  = 8;                     // one activation channel
  localparam int OUT_LANES = 8;                     // channels per next-layer beat
  localparam int IN_LANES  = 16;                    // channels per layer output vector
  localparam int OUT_W_DEF = ACT_BITS * OUT_LANES;  // 64
  localparam int IN_W_DEF  = ACT_BITS * IN_LANES;   // 128

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/act_repacker_if.sv
// Capture/drain bus between upstream layer, repacker and next layer.
// Combinational signal bundle, no latency.
// Upstream side has no backpressure; downstream side is valid/ready.
// Ports: in_valid/in_act (capture strobe + vector), out_act/out_valid/out_ready (beat handshake).
interface act_repacker_if import act_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);

  logic             in_valid;
  logic [IN_W-1:0]  in_act;
  logic [OUT_W-1:0] out_act;
  logic             out_valid;
  logic             out_ready;

  // master: the environment (upstream producer + downstream consumer)
  modport master (output in_valid, output in_act, output out_ready,
                  input  out_act,  input  out_valid);

  // slave: the repacker itself
  modport slave  (input  in_valid, input  in_act,  input  out_ready,
                  output out_act,  output out_valid);

endinterface

// File: rtl/act_fifo.sv
// Entry storage for the repacker: DEPTH x W circular buffer with write/read pointers.
// Synchronous write, combinational head read (zero read latency).
// No full/empty tracking here; the owner guarantees wr_en only when space and rd_en only when occupied.
// Ports: clk, rst (sync, active-high), wr_en/wr_dat (push), rd_en (pop head), rd_dat (head entry).
module act_fifo import act_pkg::*; #(
  parameter int W     = IN_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage itself is not reset; a write during reset is suppressed so a
  // capture strobe coinciding with reset cannot leave a stale entry behind.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/act_repacker.sv
// Repacks IN_W-bit layer outputs into two OUT_W-bit beats (low channels first) for the next layer.
// Latency: capture in cycle N gives out_valid in N+1 when empty; beats hold while out_ready is low.
// Upstream cannot be stalled: captures arriving while full (and no entry freed that cycle) are dropped and counted.
// Ports: clk, rst (sync, active-high), bus (act_repacker_if.slave), level (occupancy 0..DEPTH),
//        overflow (sticky drop flag), drop_cnt (saturating drop count).
module act_repacker import act_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  act_repacker_if.slave              bus,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [LW-1:0]   level_q;
  logic            half_q;      // 0: head entry shows beat 0, 1: beat 1
  logic            ovf_q;
  logic [7:0]      drop_q;
  logic [IN_W-1:0] head;

  logic full;
  logic xfer;
  logic pop;
  logic accept;
  logic drop;

  assign full   = (level_q == LW'(DEPTH));
  assign xfer   = bus.out_valid && bus.out_ready;
  // An entry is freed only when its second beat leaves.
  assign pop    = xfer && half_q;
  // The slot freed by a same-cycle beat-1 transfer is reusable immediately,
  // so a full buffer still accepts a capture in that cycle.
  assign accept = bus.in_valid && (!full || pop);
  assign drop   = bus.in_valid && full && !pop;

  act_fifo #(
    .W     (IN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (accept),
    .wr_dat (bus.in_act),
    .rd_en  (pop),
    .rd_dat (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      half_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (xfer) half_q <= !half_q;

      case ({accept, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase

      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign bus.out_valid = (level_q != '0);
  assign bus.out_act   = half_q ? head[IN_W-1:OUT_W] : head[OUT_W-1:0];
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign drop_cnt      = drop_q;

endmodule
